// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard unit; master drives detection inputs, slave drives enables/flushes.
// Pure wiring, no latency; backpressure is the enables themselves.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_branch;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [REG_W-1:0] ex_rd;
    logic             mem_mem_read;
    logic [REG_W-1:0] mem_rd;
    logic             pc_src;
    logic             ext_stall;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             if_flush;
    logic             id_flush;
    logic             stall_busy;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, ex_mem_read, ex_reg_write,
               ex_rd, mem_mem_read, mem_rd, pc_src, ext_stall,
        input  pc_write, if_id_write, id_ex_write, if_flush, id_flush, stall_busy,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, ex_mem_read, ex_reg_write,
               ex_rd, mem_mem_read, mem_rd, pc_src, ext_stall,
        output pc_write, if_id_write, id_ex_write, if_flush, id_flush, stall_busy,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard unit with multi-cycle stall down-counter and perf counters.
// Enables/flushes combinational from inputs; counters registered; ext_stall freezes the front end.
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hif
);
    localparam int CW = $clog2(LOAD_LAT + 2);
    localparam logic [CW-1:0] LAT  = CW'(LOAD_LAT);
    localparam logic [CW-1:0] LAT1 = CW'(LOAD_LAT + 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic [CW-1:0] w_need;
    logic          w_match_ex;
    logic          w_match_mem;
    logic          w_hold;
    logic          w_busy;
    logic          w_pc_write;
    logic          w_if_id_write;
    logic          w_id_ex_write;
    logic          w_if_flush;
    logic          w_id_flush;

    function automatic logic f_match(
        input logic [REG_W-1:0] x,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             use_rs,
        input logic             use_rt
    );
        logic m;
        m = (use_rs && (rs == x)) || (use_rt && (rt == x));
        if ((ZERO_REG != 0) && (x == '0))
            m = 1'b0;
        return m;
    endfunction

    assign w_match_ex  = f_match(hif.ex_rd,  hif.id_rs, hif.id_rt, hif.id_use_rs, hif.id_use_rt);
    assign w_match_mem = f_match(hif.mem_rd, hif.id_rs, hif.id_rt, hif.id_use_rs, hif.id_use_rt);

    // Load in EX dominates: LOAD_LAT(+1 for a branch) is never smaller than the other cases.
    always_comb begin
        w_need = '0;
        if (hif.mem_mem_read && w_match_mem && hif.id_branch)
            w_need = LAT;
        if (hif.ex_reg_write && !hif.ex_mem_read && w_match_ex && hif.id_branch && (w_need < ONE))
            w_need = ONE;
        if (hif.ex_mem_read && w_match_ex)
            w_need = hif.id_branch ? LAT1 : LAT;
    end

    assign w_hold = (r_cnt != '0);
    assign w_busy = !rst && (w_hold || (w_need != '0));

    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_id_ex_write = 1'b1;
        w_if_flush    = 1'b0;
        w_id_flush    = 1'b0;
        if (rst) begin
            w_pc_write = 1'b1;
        end else if (hif.ext_stall) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_write = 1'b0;
        end else if (w_busy) begin
            // Branch operands are not yet valid, so pc_src is not trusted here.
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_flush    = 1'b1;
        end else if (hif.pc_src) begin
            w_if_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!hif.ext_stall) begin
                if (w_hold)
                    r_cnt <= r_cnt - ONE;
                else if (w_need != '0)
                    r_cnt <= w_need - ONE;
            end
            if (w_busy && !hif.ext_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_if_flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

    assign hif.pc_write     = w_pc_write;
    assign hif.if_id_write  = w_if_id_write;
    assign hif.id_ex_write  = w_id_ex_write;
    assign hif.if_flush     = w_if_flush;
    assign hif.id_flush     = w_id_flush;
    assign hif.stall_busy   = w_busy;
    assign hif.stall_cycles = r_stall_cycles;
    assign hif.flush_count  = r_flush_count;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: three hazard_ctrl builds (LOAD_LAT 1/CNT_W 4, LOAD_LAT 2, LOAD_LAT 3) share one stimulus.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_use_rs, id_use_rt, id_branch, ex_mem_read, ex_reg_write;
    logic       mem_mem_read, pc_src, ext_stall;
    int         compared = 0;
    int         mismatched = 0;

    // Output vector order: pc_write, if_id_write, id_ex_write, if_flush, id_flush, stall_busy
    localparam logic [5:0] NRM  = 6'b111000;
    localparam logic [5:0] STL  = 6'b001011;
    localparam logic [5:0] BRT  = 6'b111100;
    localparam logic [5:0] FRZ  = 6'b000000;
    localparam logic [5:0] FRZH = 6'b000001;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  i1 ();
    hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) i2 ();
    hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) i3 ();

    assign {i1.id_rs, i1.id_rt, i1.id_use_rs, i1.id_use_rt, i1.id_branch, i1.ex_mem_read, i1.ex_reg_write,
            i1.ex_rd, i1.mem_mem_read, i1.mem_rd, i1.pc_src, i1.ext_stall} =
           {id_rs, id_rt, id_use_rs, id_use_rt, id_branch, ex_mem_read, ex_reg_write,
            ex_rd, mem_mem_read, mem_rd, pc_src, ext_stall};
    assign {i2.id_rs, i2.id_rt, i2.id_use_rs, i2.id_use_rt, i2.id_branch, i2.ex_mem_read, i2.ex_reg_write,
            i2.ex_rd, i2.mem_mem_read, i2.mem_rd, i2.pc_src, i2.ext_stall} =
           {id_rs, id_rt, id_use_rs, id_use_rt, id_branch, ex_mem_read, ex_reg_write,
            ex_rd, mem_mem_read, mem_rd, pc_src, ext_stall};
    assign {i3.id_rs, i3.id_rt, i3.id_use_rs, i3.id_use_rt, i3.id_branch, i3.ex_mem_read, i3.ex_reg_write,
            i3.ex_rd, i3.mem_mem_read, i3.mem_rd, i3.pc_src, i3.ext_stall} =
           {id_rs, id_rt, id_use_rs, id_use_rt, id_branch, ex_mem_read, ex_reg_write,
            ex_rd, mem_mem_read, mem_rd, pc_src, ext_stall};

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(4))  d1 (.clk(clk), .rst(rst), .hif(i1));
    hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .ZERO_REG(1), .CNT_W(32)) d2 (.clk(clk), .rst(rst), .hif(i2));
    hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .ZERO_REG(1), .CNT_W(32)) d3 (.clk(clk), .rst(rst), .hif(i3));

    wire [5:0] o1 = {i1.pc_write, i1.if_id_write, i1.id_ex_write, i1.if_flush, i1.id_flush, i1.stall_busy};
    wire [5:0] o2 = {i2.pc_write, i2.if_id_write, i2.id_ex_write, i2.if_flush, i2.id_flush, i2.stall_busy};
    wire [5:0] o3 = {i3.pc_write, i3.if_id_write, i3.id_ex_write, i3.if_flush, i3.id_flush, i3.stall_busy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_branch = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
        mem_mem_read = 1'b0; mem_rd = 5'd0; pc_src = 1'b0; ext_stall = 1'b0;
    endtask

    // lw $2 in EX, add reading $2/$3 in ID
    task automatic load_use();
        set_idle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd2;
        id_rs = 5'd2; id_rt = 5'd3; id_use_rs = 1'b1; id_use_rt = 1'b1;
        #1;
    endtask

    task automatic ex_bubble();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        // Reset forces idle outputs even with a hazard present
        load_use();
        chk("rst_outputs", o1, NRM);
        tick();
        rst = 1'b0;
        set_idle();
        #1;
        chkc("rst_stall_d1", i1.stall_cycles, 0);
        chkc("rst_flush_d1", i1.flush_count, 0);
        chkc("rst_stall_d3", i3.stall_cycles, 0);

        // Load-use with LOAD_LAT 1, 2, 3 simultaneously
        load_use();
        chk("lu_c0_d1", o1, STL);
        chk("lu_c0_d2", o2, STL);
        chk("lu_c0_d3", o3, STL);
        tick();
        ex_bubble();
        chk("lu_c1_d1", o1, NRM);
        chk("lu_c1_d2", o2, STL);
        chk("lu_c1_d3", o3, STL);
        chkc("lu_stall_d1", i1.stall_cycles, 1);
        tick();
        chk("lu_c2_d2", o2, NRM);
        chk("lu_c2_d3", o3, STL);
        tick();
        chk("lu_c3_d3", o3, NRM);
        chkc("lu_stall_d2", i2.stall_cycles, 2);
        chkc("lu_stall_d3", i3.stall_cycles, 3);

        // beq $2 behind lw $2 with pc_src asserted throughout
        do_reset();
        id_rs = 5'd2; id_rt = 5'd4; id_use_rs = 1'b1; id_use_rt = 1'b1; id_branch = 1'b1;
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd2; pc_src = 1'b1;
        #1;
        chk("blw_c0_d1", o1, STL);
        chk("blw_c0_d2", o2, STL);
        tick();
        ex_bubble();
        mem_mem_read = 1'b1; mem_rd = 5'd2;
        #1;
        chk("blw_c1_d1", o1, STL);
        chk("blw_c1_d2", o2, STL);
        tick();
        mem_mem_read = 1'b0; mem_rd = 5'd0;
        #1;
        chk("blw_c2_d1_taken", o1, BRT);
        chk("blw_c2_d2", o2, STL);
        tick();
        chkc("blw_stall_d1", i1.stall_cycles, 2);
        chkc("blw_flush_d1", i1.flush_count, 1);
        chkc("blw_stall_d2", i2.stall_cycles, 3);

        // beq $5 behind add $5: one bubble
        set_idle();
        id_rs = 5'd5; id_rt = 5'd6; id_use_rs = 1'b1; id_use_rt = 1'b1; id_branch = 1'b1;
        ex_reg_write = 1'b1; ex_rd = 5'd5; pc_src = 1'b1;
        #1;
        chk("balu_c0_d1", o1, STL);
        tick();
        ex_bubble();
        chk("balu_c1_d1", o1, BRT);
        tick();
        chkc("balu_stall_d1", i1.stall_cycles, 3);
        chkc("balu_flush_d1", i1.flush_count, 2);

        // Register 0 and unused rt never hazard
        set_idle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0;
        id_use_rs = 1'b1; id_use_rt = 1'b1;
        #1;
        chk("zero_reg_d1", o1, NRM);
        ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_use_rt = 1'b0;
        #1;
        chk("unused_rt_d1", o1, NRM);
        id_use_rt = 1'b1;
        #1;
        chk("used_rt_d1", o1, STL);
        tick();
        set_idle();
        #1;
        chk("used_rt_rel_d1", o1, NRM);
        chkc("used_rt_stall_d1", i1.stall_cycles, 4);

        // External freeze in the middle of a LOAD_LAT=2 hold
        do_reset();
        load_use();
        chk("frz_c0_d2", o2, STL);
        tick();
        ex_bubble();
        ext_stall = 1'b1;
        pc_src = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("frz_hold_d2", o2, FRZH);
            chk("frz_idle_d1", o1, FRZ);
            chkc("frz_stall_d2", i2.stall_cycles, 1);
            tick();
        end
        ext_stall = 1'b0;
        pc_src = 1'b0;
        #1;
        chk("frz_rel_d2", o2, STL);
        tick();
        chk("frz_done_d2", o2, NRM);
        chkc("frz_total_d2", i2.stall_cycles, 2);

        // Taken branch without hazard, flush counter saturation on the 4-bit build
        do_reset();
        pc_src = 1'b1;
        #1;
        chk("taken_d1", o1, BRT);
        tick();
        chkc("flush_one_d1", i1.flush_count, 1);
        repeat (15) tick();
        chkc("flush_sat_d1", i1.flush_count, 15);
        chkc("flush_nosat_d2", i2.flush_count, 16);
        tick();
        chkc("flush_sat_hold_d1", i1.flush_count, 15);

        // Reset in the middle of a LOAD_LAT=3 hold
        load_use();
        chk("rh_c0_d3", o3, STL);
        tick();
        ex_bubble();
        chkc("rh_stall_d3", i3.stall_cycles, 1);
        chk("rh_c1_d3", o3, STL);
        rst = 1'b1;
        #1;
        chk("rh_in_rst_d3", o3, NRM);
        tick();
        rst = 1'b0;
        set_idle();
        #1;
        chk("rh_after_d3", o3, NRM);
        chkc("rh_stall_clr_d3", i3.stall_cycles, 0);
        chkc("rh_flush_clr_d3", i3.flush_count, 0);
        chkc("rh_flush_clr_d1", i1.flush_count, 0);
        tick();
        chk("rh_after2_d3", o3, NRM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
